sm4_round_core: RTL

- Iterative SM4 encryption datapath that sits directly downstream of the key-expansion block.
- Latches the 32 round keys that block produces (1024-bit bus plus valid) and encrypts 128-bit blocks over 32 rounds.
- Returns ciphertext through a valid/ready handshake to the CTR-mode wrapper.
- S-box is a 256-entry constant function inside this block.

---
 rtl/sm4_round_core.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/sm4_round_core.sv
// sm4_round_core
// Iterative SM4 block-cipher datapath. Sits behind the key-expansion block,
// latches its 32 round keys and runs one 128-bit block at a time over
// 32/RPC cycles. Ciphertext leaves through a valid/ready handshake.
//
// Parameters:
//   RPC  rounds computed per clock (1, 2 or 4)
//
// Optional feature (macro SM4_DECRYPT_EN):
//   adds core_din_dec; when set at the input handshake the round keys are
//   applied in reverse order, which decrypts the block.
//
// Ports:
//   clk_sys            system clock
//   sys_rst_n          asynchronous active-low reset
//   key2core_rkey      round keys, rk0 = [1023:992] ... rk31 = [31:0]
//   key2core_rkey_vld  one-cycle strobe qualifying key2core_rkey
//   core_din           plaintext block, X0 = [127:96]
//   core_din_vld       plaintext valid
//   core_din_dec       decrypt select (SM4_DECRYPT_EN only)
//   core_din_rdy       block can be accepted
//   core_dout          ciphertext block
//   core_dout_vld      ciphertext valid
//   core_dout_rdy      downstream accepts ciphertext
//   core_busy          core is not idle
module sm4_round_core #(
    parameter int unsigned RPC = 1
) (
    input  logic          clk_sys,
    input  logic          sys_rst_n,
    input  logic [1023:0] key2core_rkey,
    input  logic          key2core_rkey_vld,
    input  logic [127:0]  core_din,
    input  logic          core_din_vld,
`ifdef SM4_DECRYPT_EN
    input  logic          core_din_dec,
`endif
    output logic          core_din_rdy,
    output logic [127:0]  core_dout,
    output logic          core_dout_vld,
    input  logic          core_dout_rdy,
    output logic          core_busy
);

    // SM4 S-box, entry n occupies bits [8n +: 8] of an ascending vector.
    localparam logic [0:2047] SBOX = {
        128'hd690e9fecce13db716b614c228fb2c05,
        128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62,
        128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8,
        128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887,
        128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1,
        128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f,
        128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8,
        128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684,
        128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    localparam logic [4:0] CntStep = 5'(RPC);
    localparam logic [4:0] CntLast = 5'(32 - RPC);

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{b, 3'b000} +: 8];
    endfunction

    // T = L(tau): byte-wise S-box followed by the linear diffusion layer.
    function automatic logic [31:0] t_func(input logic [31:0] a);
        logic [31:0] b;
        b = {sbox(a[31:24]), sbox(a[23:16]), sbox(a[15:8]), sbox(a[7:0])};
        return b ^ {b[29:0], b[31:30]} ^ {b[21:0], b[31:22]}
                 ^ {b[13:0], b[31:14]} ^ {b[7:0], b[31:8]};
    endfunction

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e        state_q, state_d;
    logic [4:0]    cnt_q, cnt_d;
    logic [127:0]  x_q, x_d;
    logic [1023:0] key_q, key_d;
    logic [1023:0] shadow_q, shadow_d;
    logic          pending_q, pending_d;
    logic          key_loaded_q, key_loaded_d;
    logic [127:0]  dout_q, dout_d;
    logic          dout_vld_q, dout_vld_d;
    logic          dec_q;
    logic [127:0]  x_step;
    logic          din_fire;

    assign core_din_rdy  = (state_q == StIdle) && key_loaded_q;
    assign core_dout     = dout_q;
    assign core_dout_vld = dout_vld_q;
    assign core_busy     = (state_q != StIdle);
    assign din_fire      = core_din_vld && core_din_rdy;

    // RPC chained rounds per cycle. The key word is picked by a mux on the
    // round index; decryption just complements the index (31 - i).
    always_comb begin : round_chain
        logic [127:0] x;
        logic [4:0]   idx;
        logic [31:0]  rk;
        x   = x_q;
        idx = '0;
        rk  = '0;
        for (int j = 0; j < RPC; j++) begin
            idx = cnt_q + 5'(j);
            if (dec_q) begin
                idx = ~idx;
            end
            rk = key_q[{~idx, 5'b00000} +: 32];
            x  = {x[95:0], x[127:96] ^ t_func(x[95:64] ^ x[63:32] ^ x[31:0] ^ rk)};
        end
        x_step = x;
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        x_d          = x_q;
        key_d        = key_q;
        shadow_d     = shadow_q;
        pending_d    = pending_q;
        key_loaded_d = key_loaded_q;
        dout_d       = dout_q;
        dout_vld_d   = dout_vld_q;

        // Keys arriving mid-block are parked so the running block keeps its schedule.
        if (key2core_rkey_vld) begin
            if (state_q == StRun) begin
                shadow_d  = key2core_rkey;
                pending_d = 1'b1;
            end else begin
                key_d        = key2core_rkey;
                key_loaded_d = 1'b1;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (din_fire) begin
                    x_d     = core_din;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                x_d   = x_step;
                cnt_d = cnt_q + CntStep;
                if (cnt_q == CntLast) begin
                    // x_step = {X32, X33, X34, X35}; output is the reversed order.
                    dout_d     = {x_step[31:0], x_step[63:32], x_step[95:64], x_step[127:96]};
                    dout_vld_d = 1'b1;
                    state_d    = StDone;
                    // A strobe on this very edge is the newest schedule and wins.
                    if (key2core_rkey_vld) begin
                        key_d     = key2core_rkey;
                        pending_d = 1'b0;
                    end else if (pending_q) begin
                        key_d     = shadow_q;
                        pending_d = 1'b0;
                    end
                end
            end
            StDone: begin
                if (core_dout_rdy) begin
                    dout_vld_d = 1'b0;
                    state_d    = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_sys or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            x_q          <= '0;
            key_q        <= '0;
            shadow_q     <= '0;
            pending_q    <= 1'b0;
            key_loaded_q <= 1'b0;
            dout_q       <= '0;
            dout_vld_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            x_q          <= x_d;
            key_q        <= key_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            key_loaded_q <= key_loaded_d;
            dout_q       <= dout_d;
            dout_vld_q   <= dout_vld_d;
        end
    end

`ifdef SM4_DECRYPT_EN
    always_ff @(posedge clk_sys or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            dec_q <= 1'b0;
        end else if (din_fire) begin
            dec_q <= core_din_dec;
        end
    end
`else
    assign dec_q = 1'b0;
`endif

endmodule
